// File: rtl/edb_pkg.sv
// Shared types for the edb-cl datapath blocks: the op encoding used by the
// add/subtract/accumulate unit and its stimulus driver.
package edb_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'b00,
      OP_SUB = 2'b01,
      OP_ACC = 2'b10,
      OP_CLR = 2'b11
   } op_e;

endpackage

// File: rtl/pipe_addsub_acc_if.sv
// Valid/ready request and result bus of the add/sub/accumulate unit.
// The master drives ops and takes results; the slave is the unit itself.
interface pipe_addsub_acc_if #(
   parameter int WIDTH = 32
);
   import edb_pkg::*;

   logic             in_valid;
   logic             in_ready;
   op_e              in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_c;
   logic             out_carry;
   logic             out_ovf;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_c, out_carry, out_ovf
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_c, out_carry, out_ovf
   );

endinterface

// File: rtl/add_core.sv
// Combinational arithmetic of the unit: one shared adder serves ADD, SUB and ACC,
// and the next accumulator value is produced alongside the result.
module add_core
   import edb_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] acc,
   output logic [WIDTH-1:0] c,
   output logic             carry,
   output logic             ovf,
   output logic [WIDTH-1:0] acc_nxt
);

   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             cin;
   logic [WIDTH:0]   sum;

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      x   = a;
      y   = b;
      cin = 1'b0;
      case (op)
         OP_SUB: begin
            y   = ~b;
            cin = 1'b1;
         end
         OP_ACC: begin
            x = acc;
            y = a;
         end
         OP_CLR: begin
            x = '0;
            y = '0;
         end
         default: ;
      endcase
      sum     = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
      c       = sum[WIDTH-1:0];
      carry   = sum[WIDTH];
      // Overflow: both adder inputs share a sign that the result does not.
      ovf     = (x[WIDTH-1] == y[WIDTH-1]) & (c[WIDTH-1] != x[WIDTH-1]);
      acc_nxt = (op == OP_ACC) ? c : (op == OP_CLR) ? '0 : acc;
   end

endmodule

// File: rtl/pipe_addsub_acc.sv
// Pipelined add/sub/accumulate unit: arithmetic on accept, then a STAGES-deep
// valid/data shift register that advances as a whole unless the output is stalled.
module pipe_addsub_acc
   import edb_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   pipe_addsub_acc_if.slave   bus
);

   typedef struct packed {
      logic [WIDTH-1:0] c;
      logic             carry;
      logic             ovf;
   } result_t;

   logic             adv;
   logic             accept;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] core_c;
   logic             core_carry;
   logic             core_ovf;
   result_t          core_res;
   logic             vld_q [STAGES];
   result_t          dat_q [STAGES];

   add_core #(.WIDTH(WIDTH)) u_core (
      .op      (bus.in_op),
      .a       (bus.in_a),
      .b       (bus.in_b),
      .acc     (acc_q),
      .c       (core_c),
      .carry   (core_carry),
      .ovf     (core_ovf),
      .acc_nxt (acc_nxt)
   );

   assign core_res = {core_c, core_carry, core_ovf};
   assign adv      = ~vld_q[STAGES-1] | bus.out_ready;
   assign accept   = bus.in_valid & adv;

   // The accumulator moves at accept time so back-to-back ACC/CLR chain without waiting for the pipe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q <= '0;
      end else if (accept) begin
         acc_q <= acc_nxt;
      end
   end

   // NOTE: the data stages are reset as well as the valids, so out_c and flags read 0 after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < STAGES; i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
         end
      end else if (adv) begin
         vld_q[0] <= accept;
         dat_q[0] <= core_res;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            dat_q[i] <= dat_q[i-1];
         end
      end
   end

   assign bus.in_ready  = adv;
   assign bus.out_valid = vld_q[STAGES-1];
   assign bus.out_c     = dat_q[STAGES-1].c;
   assign bus.out_carry = dat_q[STAGES-1].carry;
   assign bus.out_ovf   = dat_q[STAGES-1].ovf;

endmodule
